// File: rtl/async_fifo_fwft_reader.sv
// Read-side consumer of the async FIFO: turns the registered-data pop interface into a
// first-word-fall-through valid/ready stream, using a head register and a skid register.
module async_fifo_fwft_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   read_clk,
  input  logic                   read_rst_n,
  input  logic                   p_read_empty,
  input  logic [DATA_WIDTH-1:0]  p_read_data,
  output logic                   p_read_en,
  output logic                   m_valid,
  output logic [DATA_WIDTH-1:0]  m_data,
  input  logic                   m_ready,
  output logic [1:0]             occupancy,
  output logic [COUNT_WIDTH-1:0] rd_word_cnt
);

  logic                   head_valid_reg, head_valid_next;
  logic [DATA_WIDTH-1:0]  head_data_reg, head_data_next;
  logic                   skid_valid_reg, skid_valid_next;
  logic [DATA_WIDTH-1:0]  skid_data_reg, skid_data_next;
  logic                   inflight_reg;
  logic [COUNT_WIDTH-1:0] cnt_reg;
  logic                   pop_out;
  logic [1:0]             credit_used;

  assign pop_out     = head_valid_reg && m_ready;
  assign credit_used = {1'b0, head_valid_reg} + {1'b0, skid_valid_reg} + {1'b0, inflight_reg};

  // A slot freed by this cycle's pop_out can be reused by a pop issued in the same cycle.
  assign p_read_en = read_rst_n && !p_read_empty && ((credit_used < 2'd2) || pop_out);

  always_comb begin
    head_valid_next = head_valid_reg;
    head_data_next  = head_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (pop_out) begin
      if (skid_valid_reg) begin
        head_data_next  = skid_data_reg;
        skid_valid_next = inflight_reg;
        if (inflight_reg) skid_data_next = p_read_data;
      end else begin
        head_valid_next = inflight_reg;
        if (inflight_reg) head_data_next = p_read_data;
      end
    end else if (inflight_reg) begin
      if (!head_valid_reg) begin
        head_valid_next = 1'b1;
        head_data_next  = p_read_data;
      end else begin
        skid_valid_next = 1'b1;
        skid_data_next  = p_read_data;
      end
    end
  end

  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      inflight_reg   <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      head_valid_reg <= head_valid_next;
      head_data_reg  <= head_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      inflight_reg   <= p_read_en;
      cnt_reg        <= cnt_reg + COUNT_WIDTH'(pop_out);
    end
  end

  assign m_valid     = head_valid_reg;
  assign m_data      = head_data_reg;
  assign occupancy   = {1'b0, head_valid_reg} + {1'b0, skid_valid_reg};
  assign rd_word_cnt = cnt_reg;

endmodule

// File: tb/tb_async_fifo_fwft_reader.sv
// Bench for async_fifo_fwft_reader: models the FIFO read port and scores the output stream
// against the words pushed, with word-count accounting for occupancy and credits.
module tb_async_fifo_fwft_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       empty = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       ready = 1'b0;
  logic       pe;
  logic       mv;
  logic [7:0] md;
  logic [1:0] occ;
  logic [3:0] cnt;

  async_fifo_fwft_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut (
    .read_clk    (clk),
    .read_rst_n  (rst_n),
    .p_read_empty(empty),
    .p_read_data (rdata),
    .p_read_en   (pe),
    .m_valid     (mv),
    .m_data      (md),
    .m_ready     (ready),
    .occupancy   (occ),
    .rd_word_cnt (cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int delivered = 0;
  int captured = 0;
  int inflight_exp = 0;
  bit data_pending = 0;
  logic [7:0] rd_next = 8'h00;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int ready_mode = 1;
  bit rnd_empty = 0;
  bit rdy_toggle = 0;
  bit stall_prev = 0;
  logic [7:0] stall_data = 8'h00;
  int phase_pops, phase_hs, first_pop_cyc, first_hs_cyc, last_hs_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic phase_clear();
    phase_pops = 0;
    phase_hs = 0;
    first_pop_cyc = -1;
    first_hs_cyc = -1;
    last_hs_cyc = -1;
  endtask

  // One clock cycle: drive inputs just after the rising edge, check at the falling edge,
  // then advance the FIFO model at the next rising edge.
  task automatic step();
    bit hs;
    bit pe_s;
    bit exp_pe;
    int occ_exp;
    case (ready_mode)
      0: ready = 1'b0;
      1: ready = 1'b1;
      2: begin rdy_toggle = !rdy_toggle; ready = rdy_toggle; end
      default: ready = 1'($urandom_range(0, 1));
    endcase
    empty = (fifo_q.size() == 0) || (rnd_empty && ($urandom_range(0, 3) == 0));
    rdata = data_pending ? rd_next : 8'($urandom);
    @(negedge clk);
    occ_exp = captured - delivered;
    check("occupancy", 32'(occ), 32'(occ_exp));
    check("m_valid", 32'(mv), 32'(occ_exp != 0));
    check("rd_word_cnt", 32'(cnt), 32'(delivered % 16));
    exp_pe = !empty && (((occ_exp + inflight_exp) < 2) || ((occ_exp != 0) && ready));
    check("p_read_en", 32'(pe), 32'(exp_pe));
    if (stall_prev) begin
      check("stall_valid", 32'(mv), 32'd1);
      check("stall_data", 32'(md), 32'(stall_data));
    end
    hs = mv && ready;
    if (hs) begin
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("m_data_order", 32'(md), 32'(exp_q.pop_front()));
      delivered++;
      phase_hs++;
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
    end
    stall_prev = mv && !ready;
    stall_data = md;
    pe_s = pe;
    if (pe_s) begin
      phase_pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
    end
    @(posedge clk);
    captured += inflight_exp;
    inflight_exp = int'(pe_s);
    data_pending = pe_s;
    if (pe_s && fifo_q.size() != 0) rd_next = fifo_q.pop_front();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_async_m_valid", 32'(mv), 32'd0);
    check("rst_async_occupancy", 32'(occ), 32'd0);
    check("rst_async_p_read_en", 32'(pe), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    captured = 0;
    delivered = 0;
    inflight_exp = 0;
    data_pending = 0;
    stall_prev = 0;
    rdy_toggle = 0;
    empty = 1'b1;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_data", 32'(md), 32'd0);
    check("rst_rd_word_cnt", 32'(cnt), 32'd0);
    check("rst_m_valid", 32'(mv), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    do_reset();

    // 1: idle with FIFO empty
    ready_mode = 1;
    repeat (10) step();
    $display("test1 idle: total=%0d bad=%0d", total, bad);

    // 2: three words at full rate, latency and back-to-back delivery
    phase_clear();
    push(8'h11); push(8'h22); push(8'h33);
    repeat (8) step();
    check("t2_latency", 32'(first_hs_cyc - first_pop_cyc), 32'd2);
    check("t2_back_to_back", 32'(last_hs_cyc - first_hs_cyc), 32'd2);
    check("t2_cnt", 32'(cnt), 32'd3);
    check("t2_drained", 32'(exp_q.size()), 32'd0);
    $display("test2 three words: total=%0d bad=%0d", total, bad);

    // 3: stalled downstream fills exactly two slots, then drains without gaps
    phase_clear();
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
    ready_mode = 0;
    repeat (6) step();
    check("t3_pops_while_stalled", 32'(phase_pops), 32'd2);
    check("t3_occupancy_full", 32'(occ), 32'd2);
    check("t3_head_word", 32'(md), 32'h40);
    phase_clear();
    ready_mode = 1;
    repeat (12) step();
    check("t3_words_out", 32'(phase_hs), 32'd8);
    check("t3_no_gaps", 32'(last_hs_cyc - first_hs_cyc), 32'd7);
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    $display("test3 stall/drain: total=%0d bad=%0d", total, bad);

    // 4: alternating ready over 16 words
    ready_mode = 2;
    for (int i = 0; i < 16; i++) push(8'(i));
    repeat (40) step();
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    $display("test4 toggled ready: total=%0d bad=%0d", total, bad);

    // 5: counter wrap with 4-bit count (27 delivered so far)
    ready_mode = 1;
    for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
    repeat (25) step();
    check("t5_delivered", 32'(delivered), 32'd44);
    check("t5_cnt_wrapped", 32'(cnt), 32'd12);
    $display("test5 counter wrap: total=%0d bad=%0d", total, bad);

    // random ready and empty glitches
    ready_mode = 3;
    rnd_empty = 1;
    for (int i = 0; i < 60; i++) push(8'($urandom));
    repeat (220) step();
    rnd_empty = 0;
    ready_mode = 1;
    repeat (6) step();
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    $display("random phase: total=%0d bad=%0d", total, bad);

    // 6: reset with a buffered word and a pop in flight
    ready_mode = 0;
    for (int i = 0; i < 5; i++) push(8'(8'hB0 + i));
    repeat (2) step();
    check("t6_pre_occupancy", 32'(occ), 32'd1);
    check("t6_pre_inflight", 32'(inflight_exp), 32'd1);
    do_reset();
    ready_mode = 1;
    for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
    repeat (10) step();
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    check("t6_cnt", 32'(cnt), 32'd4);
    $display("test6 reset mid-op: total=%0d bad=%0d", total, bad);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
